// File: rtl/compfree_sorter.sv
// Comparison-free sorter: loads ELEMENT_NUM words, then selects each rank by masking bit columns MSB->LSB.
// First write DATA_WIDTH+1 cycles after the last input; SORTER_DESCEND_EN selects descending order.
module compfree_sorter #(
    parameter int DATA_WIDTH       = 32,
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        UM_valid,
    input  logic [DATA_WIDTH-1:0]       UM_data,
    output logic                        SM_valid,
    output logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
    output logic [DATA_WIDTH-1:0]       SM_data,
    output logic                        done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(DATA_WIDTH - 1);
    localparam logic [LOG2_ELEMENT_NUM-1:0] CNT_LAST = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    typedef enum logic [1:0] {LOAD, SCAN, EMIT, DONE} state_t;

    state_t                        state_q, state_d;
    logic [DATA_WIDTH-1:0]         mem_q [ELEMENT_NUM];
    logic [LOG2_ELEMENT_NUM-1:0]   in_cnt_q, in_cnt_d;
    logic [LOG2_ELEMENT_NUM-1:0]   out_cnt_q, out_cnt_d;
    logic [ELEMENT_NUM-1:0]        remaining_q, remaining_d;
    logic [ELEMENT_NUM-1:0]        cand_q, cand_d;
    logic [BW-1:0]                 bit_q, bit_d;
    logic                          sm_valid_q, sm_valid_d;
    logic [LOG2_ELEMENT_NUM-1:0]   sm_addr_q, sm_addr_d;
    logic [DATA_WIDTH-1:0]         sm_data_q, sm_data_d;
    logic                          done_q, done_d;

    logic [ELEMENT_NUM-1:0]        col;
    logic [ELEMENT_NUM-1:0]        z;
    logic [ELEMENT_NUM-1:0]        sel_onehot;
    logic [LOG2_ELEMENT_NUM-1:0]   sel;
    logic                          wr_en;

    always_comb begin
        col = '0;
        for (int i = 0; i < ELEMENT_NUM; i++) begin
            col[i] = mem_q[i][bit_q];
        end
    end

    // Keep only candidates holding the preferred bit; an empty result means the column does not discriminate.
`ifdef SORTER_DESCEND_EN
    assign z = cand_q & col;
`else
    assign z = cand_q & ~col;
`endif

    // Lowest index wins so equal values leave in input order.
    always_comb begin
        sel = '0;
        for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
            if (cand_q[i]) begin
                sel = LOG2_ELEMENT_NUM'(i);
            end
        end
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign wr_en = (state_q == LOAD) && UM_valid;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        remaining_d = remaining_q;
        cand_d      = cand_q;
        bit_d       = bit_q;
        sm_valid_d  = 1'b0;
        sm_addr_d   = sm_addr_q;
        sm_data_d   = sm_data_q;
        done_d      = 1'b0;
        case (state_q)
            LOAD: begin
                if (UM_valid) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == CNT_LAST) begin
                        state_d     = SCAN;
                        remaining_d = '1;
                        cand_d      = '1;
                        bit_d       = BIT_TOP;
                        out_cnt_d   = '0;
                    end
                end
            end
            SCAN: begin
                if (z != '0) begin
                    cand_d = z;
                end
                if (bit_q == '0) begin
                    state_d = EMIT;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            EMIT: begin
                sm_valid_d  = 1'b1;
                sm_addr_d   = out_cnt_q;
                sm_data_d   = mem_q[sel];
                remaining_d = remaining_q & ~sel_onehot;
                cand_d      = remaining_q & ~sel_onehot;
                out_cnt_d   = out_cnt_q + 1'b1;
                bit_d       = BIT_TOP;
                state_d     = (out_cnt_q == CNT_LAST) ? DONE : SCAN;
            end
            DONE: begin
                done_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            remaining_q <= '0;
            cand_q      <= '0;
            bit_q       <= '0;
            sm_valid_q  <= 1'b0;
            sm_addr_q   <= '0;
            sm_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            remaining_q <= remaining_d;
            cand_q      <= cand_d;
            bit_q       <= bit_d;
            sm_valid_q  <= sm_valid_d;
            sm_addr_q   <= sm_addr_d;
            sm_data_q   <= sm_data_d;
            done_q      <= done_d;
        end
    end

    // Element storage needs no reset: it is always fully rewritten before a scan reads it.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[in_cnt_q] <= UM_data;
        end
    end

    assign SM_valid = sm_valid_q;
    assign SM_addr  = sm_addr_q;
    assign SM_data  = sm_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_compfree_sorter.sv
// Bench for compfree_sorter: table of job patterns plus random jobs against a rank-counting sort model.
module tb_compfree_sorter;

    typedef logic [31:0] word_arr_t [16];

    typedef struct {
        string       name;
        int          mode;
        int          gap;
        int          junk;
        bit          chk_ends;
        logic [31:0] exp0;
        logic [31:0] exp15;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        UM_valid = 1'b0;
    logic [31:0] UM_data = '0;
    logic        SM_valid;
    logic [3:0]  SM_addr;
    logic [31:0] SM_data;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    compfree_sorter #(.DATA_WIDTH(32), .ELEMENT_NUM(16), .LOG2_ELEMENT_NUM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .UM_valid (UM_valid),
        .UM_data  (UM_data),
        .SM_valid (SM_valid),
        .SM_addr  (SM_addr),
        .SM_data  (SM_data),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    // Stable sort by rank: position = number of strictly preferred values + equal values at lower index.
    function automatic word_arr_t ref_sort(input word_arr_t v);
        word_arr_t e;
        for (int i = 0; i < 16; i++) begin
            int r = 0;
            for (int j = 0; j < 16; j++) begin
`ifdef SORTER_DESCEND_EN
                if (v[j] > v[i] || (v[j] == v[i] && j < i)) r++;
`else
                if (v[j] < v[i] || (v[j] == v[i] && j < i)) r++;
`endif
            end
            e[r] = v[i];
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        UM_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_valid_done", {30'd0, SM_valid, done}, 32'd0);
        end
        check("rst_addr", {28'd0, SM_addr}, 32'd0);
        check("rst_data", SM_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stream(input word_arr_t v, input int gap, output int t_acc);
        for (int i = 0; i < 16; i++) begin
            int idle = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
            repeat (idle) begin
                @(negedge clk);
                UM_valid = 1'b0;
                UM_data  = $urandom;
            end
            @(negedge clk);
            UM_valid = 1'b1;
            UM_data  = v[i];
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
    endtask

    task automatic run_job(input string nm, input word_arr_t v, input int gap, input int junk,
                           output word_arr_t got);
        word_arr_t exp;
        int t_acc, nw, t_first, t_done;
        bit seen;
        exp = ref_sort(v);
        for (int i = 0; i < 16; i++) got[i] = 'x;
        do_reset();
        stream(v, gap, t_acc);
        // Extra words offered after the job is loaded must be dropped.
        repeat (junk) begin
            @(negedge clk);
            UM_valid = 1'b1;
            UM_data  = $urandom;
        end
        @(negedge clk);
        UM_valid = 1'b0;
        nw = 0; t_first = -1; t_done = -1; seen = 1'b0;
        while (!seen && (cyc - t_acc) < 700) begin
            @(posedge clk);
            #1;
            if (SM_valid) begin
                if (nw == 0) t_first = cyc - t_acc;
                if (nw < 16) begin
                    check({nm, "_addr"}, {28'd0, SM_addr}, nw);
                    check({nm, "_data"}, SM_data, exp[nw]);
                    got[nw] = SM_data;
                end
                nw++;
            end
            if (done) begin
                seen   = 1'b1;
                t_done = cyc - t_acc;
            end
        end
        check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({nm, "_nwrites"}, nw, 32'd16);
        check({nm, "_first_lat"}, t_first, 32'd33);
        check({nm, "_done_lat"}, t_done, 32'd529);
        repeat (4) begin
            @(posedge clk);
            #1;
            check({nm, "_done_hold"}, {30'd0, done, SM_valid}, 32'd2);
        end
    endtask

    initial begin
        vec_t      tbl [7];
        word_arr_t v, got;
        int        t_dummy;

        tbl[0] = '{"rand",      0, 0, 0, 1'b0, 32'h0, 32'h0};
`ifdef SORTER_DESCEND_EN
        tbl[1] = '{"desc_list", 1, 0, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0};
        tbl[3] = '{"unsigned",  3, 3, 0, 1'b1, 32'h80000000, 32'h00000000};
        tbl[4] = '{"ramp",      4, 0, 0, 1'b1, 32'd15, 32'd0};
`else
        tbl[1] = '{"desc_list", 1, 0, 0, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF};
        tbl[3] = '{"unsigned",  3, 3, 0, 1'b1, 32'h00000000, 32'h80000000};
        tbl[4] = '{"ramp",      4, 0, 0, 1'b1, 32'd0, 32'd15};
`endif
        tbl[2] = '{"all5",      2, 0, 0, 1'b1, 32'h5, 32'h5};
        tbl[5] = '{"rand_gap",  0, 2, 5, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{"dups",      5, 1, 0, 1'b0, 32'h0, 32'h0};

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 16; i++) begin
                case (tbl[t].mode)
                    1:       v[i] = 32'hFFFFFFFF - i;
                    2:       v[i] = 32'h5;
                    3:       v[i] = 32'h10 + i;
                    4:       v[i] = i;
                    5:       v[i] = $urandom_range(0, 3);
                    default: v[i] = $urandom;
                endcase
            end
            if (tbl[t].mode == 3) begin
                v[0] = 32'h80000000; v[1] = 32'h0; v[2] = 32'h7FFFFFFF; v[3] = 32'h1;
            end
            run_job(tbl[t].name, v, tbl[t].gap, tbl[t].junk, got);
            if (tbl[t].chk_ends) begin
                check({tbl[t].name, "_addr0"}, got[0], tbl[t].exp0);
                check({tbl[t].name, "_addr15"}, got[15], tbl[t].exp15);
            end
        end

        // Abort a job mid-scan; the following job must reflect only the new stream.
        for (int i = 0; i < 16; i++) v[i] = $urandom;
        do_reset();
        stream(v, 0, t_dummy);
        @(negedge clk);
        UM_valid = 1'b0;
        repeat (20) @(posedge clk);
        for (int i = 0; i < 16; i++) v[i] = $urandom;
        run_job("abort", v, 0, 0, got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
